// File: rtl/dmem_req_ctrl.sv
// Data-memory request sequencer: LW/LBU/SW/SB over the valid/yumi handshake, with pipeline stall and misalign detect.
// Optional `DMEM_TIMEOUT_EN aborts a request that sits in REQ_SENT/REQ_ACKED for TIMEOUT_CYCLES cycles.
module dmem_req_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic              req_wen_i,
  input  logic              req_byte_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [35:0]       to_mem_o,
  input  logic [33:0]       from_mem_i
);
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED} dmemReqState_t;

  typedef struct packed {
    logic [31:0] writeData;
    logic        valid;
    logic        wen;
    logic        byteNotWord;
    logic        yumi;
  } memIn_t;

  typedef struct packed {
    logic [31:0] readData;
    logic        valid;
    logic        yumi;
  } memOut_t;

  dmemReqState_t     state;
  logic [ADDR_W-1:0] addrR;
  logic              wenR, byteR;
  logic [31:0]       wdataR, rdataR;
  memOut_t           fromMem;
  memIn_t            toMem;
  logic              misalign, misDone, loadDone, storeDone, timeoutHit, doneNow;
  logic [7:0]        readByte;
  logic [31:0]       rdataNext;

  assign fromMem = from_mem_i;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Cleared on entry to REQ_SENT, so the abort lands exactly TIMEOUT_CYCLES after the request goes out.
  always_ff @(posedge clk) begin
    if (reset || state == DMEM_IDLE) cnt <= '0;
    else if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
  end

  assign timeoutHit = (state != DMEM_IDLE) && (cnt == CW'(TIMEOUT_CYCLES));
`else
  assign timeoutHit = 1'b0;
`endif

  assign misalign  = req_valid_i & ~req_byte_i & (req_addr_i[1:0] != 2'b00);
  assign misDone   = (state == DMEM_IDLE) & misalign;
  assign loadDone  = ~timeoutHit & ~wenR & fromMem.valid &
                     (((state == DMEM_REQ_SENT) & fromMem.yumi) | (state == DMEM_REQ_ACKED));
  assign storeDone = ~timeoutHit & wenR & (state == DMEM_REQ_SENT) & fromMem.yumi;
  assign doneNow   = ~reset & (loadDone | storeDone | misDone | timeoutHit);

  assign readByte  = fromMem.readData[{addrR[1:0], 3'b000} +: 8];
  assign rdataNext = loadDone ? (byteR ? {24'b0, readByte} : fromMem.readData) : 32'b0;

  always_comb begin
    toMem             = '0;
    toMem.writeData   = wdataR;
    toMem.valid       = (state == DMEM_REQ_SENT) & ~timeoutHit;
    toMem.wen         = wenR;
    toMem.byteNotWord = byteR;
    toMem.yumi        = ~reset & loadDone;
  end

  assign to_mem_o   = toMem;
  assign mem_addr_o = addrR;
  assign stall_o    = req_valid_i & ~done_o;
  assign done_o     = doneNow;
  assign err_o      = ~reset & (misDone | timeoutHit);
  // Completion value is visible during done_o and then held by the register.
  assign rdata_o    = doneNow ? rdataNext : rdataR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DMEM_IDLE;
      addrR  <= '0;
      wenR   <= 1'b0;
      byteR  <= 1'b0;
      wdataR <= '0;
      rdataR <= '0;
    end else begin
      if (doneNow) rdataR <= rdataNext;
      case (state)
        DMEM_IDLE: begin
          if (req_valid_i && !misalign) begin
            addrR  <= req_addr_i;
            wenR   <= req_wen_i;
            byteR  <= req_byte_i;
            wdataR <= req_byte_i ? {4{req_wdata_i[7:0]}} : req_wdata_i;
            state  <= DMEM_REQ_SENT;
          end
        end
        DMEM_REQ_SENT: begin
          if (timeoutHit) state <= DMEM_IDLE;
          else if (fromMem.yumi) state <= (wenR || fromMem.valid) ? DMEM_IDLE : DMEM_REQ_ACKED;
        end
        DMEM_REQ_ACKED: begin
          if (timeoutHit || fromMem.valid) state <= DMEM_IDLE;
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end
endmodule
